exc_irq_controller: RTL and testbench
=====================================

// Module: exc_irq_controller
// PURPOSE
//  Source side of the COP0 exception interface. Synchronises and latches the 7 peripheral IRQ lines.
//  Presents them as the pending-interrupt vector to COP0. Prioritises pipeline exception flags
//  against the COP0-masked interrupt vector. Issues the one-cycle exception strobe with code, BD and EPC.
//  Tracks handler occupancy until eret and applies a post-eret holdoff. Sits between pipeline/peripherals and COP0.
// PARAMETERS
//  SYNC_STAGES   2         flops in each IRQ synchroniser (>=2)
//  IRQ_EDGE      7'h7F     per-line: 1 = rising-edge latched, 0 = level (pending follows synced level)
//  ERET_HOLDOFF  1         cycles after eret during which interrupts are not taken (0..15)
// PORTS
//  iCLK              in   1   clock; the only clock
//  iCLR              in   1   reset, synchronous, active-high
//  iIRQ              in   7   raw peripheral interrupt lines (bit 0 = keyboard)
//  iPendClrWe        in   1   software clear strobe for pending bits
//  iPendClrMask      in   7   write-1-to-clear mask, used when iPendClrWe=1
//  oPendingInterrupt out  8   to COP0; [6:0]=pending latches, [7]=0 (COP0 inserts timer)
//  iInterruptMask    in   8   from COP0: IE-gated, IM-masked interrupt vector
//  iExcLevel         in   1   from COP0 SR.EL
//  iInstrValid       in   1   current instruction is real (not bubble/stall)
//  iPC               in   32  address of current instruction
//  iInBranchDelay    in   1   current instruction is in a branch delay slot
//  iAdEL,iAdES,iRI   in   1ea address error load/store, reserved instruction
//  iSyscall,iBreak   in   1ea syscall / break decoded
//  iOverflow         in   1   ALU signed overflow
//  iEret             in   1   eret executing this cycle
//  oExcOccurred      out  1   one-cycle strobe to COP0 / pipeline flush
//  oExcCode          out  5   cause code; valid with oExcOccurred
//  oBranchDelay      out  1   BD bit; valid with oExcOccurred
//  oEPC              out  32  EPC value; valid with oExcOccurred
//  oInHandler        out  1   1 while in state HANDLER
// BEHAVIOUR
//  Reset: every output is 0. Pending latches, synchronisers and holdoff counter are cleared. State is IDLE.
//  Reset mid-handler discards all state with no exception strobe.
//  IRQ path: SYNC_STAGES flops, then edge/level per IRQ_EDGE. Latency is raw edge -> pending bit = SYNC_STAGES+1 cycles.
//  An edge line sets its bit on a synced rising edge and holds it until cleared. A level line's bit follows the synced level.
//  An edge line's set and clear in the same cycle: set wins.
//  oPendingInterrupt is registered, so it lags the pending latches by 0 cycles.
//  Exception priority (high->low) and oExcCode:
//    AdEL=4, AdES=5, RI=10, Sys=8, Bp=9, Ov=12, Int=0.
//  Sync exceptions are taken only when iInstrValid=1.
//  Int is taken when all hold: |iInterruptMask, iExcLevel=0, state IDLE, holdoff counter=0, iInstrValid=1.
//  EPC/BD rule (COP0 eret returns EPC if BD, else EPC+4):
//    Sync, BD=0: EPC=iPC, BD=0.
//    Int, BD=0: EPC=iPC-4 (32-bit wrap), BD=0.
//    Any, iInBranchDelay=1: EPC=iPC-4 (the branch), BD=1.
//  FSM:
//    IDLE: exception taken -> TAKEN.
//    TAKEN: 1 cycle, oExcOccurred=1, outputs registered -> HANDLER.
//    HANDLER: iEret -> HOLDOFF (or IDLE if ERET_HOLDOFF=0).
//    HOLDOFF: counts ERET_HOLDOFF..1; sync exceptions are still taken (-> TAKEN); at 0 -> IDLE.
//  In HANDLER, interrupts are blocked. A sync exception still strobes (TAKEN again, EPC overwritten) and returns to HANDLER.
//  iEret and an exception in the same cycle: eret wins, and the exception is dropped (COP0 priority matches).
//  iEret in IDLE/HOLDOFF: ignored.
//  The strobe is never asserted two consecutive cycles.
// STRUCTURE
//  exc_pkg: exception code constants (EXC_INT..EXC_OV), FSM state encoding, priority order.
//  Sub-module irq_sync_edge (SYNC_STAGES, EDGE): one synchroniser + edge/level detector, instantiated x7.
// TESTING
//  Pulse iIRQ[0] 1 cycle, mask 8'h01, EL=0: pending[0]=1 after 3 cyc; strobe code 0, EPC=iPC-4, BD=0.
//  iOverflow+iAdEL same cycle, iPC=32'h00400010: single strobe, code 4, EPC=32'h00400010.
//  Syscall with iInBranchDelay=1, iPC=32'h00400024: code 8, BD=1, EPC=32'h00400020.
//  Interrupt pending during HANDLER: no strobe until iEret + 1 holdoff cycle; taken on next valid cycle.
//  iPendClrWe+mask 7'h01 same cycle as new edge on IRQ0: bit 0 stays 1. Clear alone: bit 0 -> 0 next cycle.
//  iCLR asserted in HANDLER with pending 7'h05: next cycle all outputs 0, state IDLE, no strobe.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt source controller:
// cause codes, FSM state encoding and the synchronous-exception priority order.
package exc_pkg;

   localparam int NUM_IRQ = 7;

   localparam logic [4:0] EXC_INT  = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_SYS  = 5'd8;
   localparam logic [4:0] EXC_BP   = 5'd9;
   localparam logic [4:0] EXC_RI   = 5'd10;
   localparam logic [4:0] EXC_OV   = 5'd12;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_TAKEN   = 2'd1,
      ST_HANDLER = 2'd2,
      ST_HOLDOFF = 2'd3
   } exc_state_e;

   // Field order is the priority order, highest first.
   typedef struct packed {
      logic adel;
      logic ades;
      logic ri;
      logic sys;
      logic bp;
      logic ov;
   } sync_flags_t;

   function automatic logic [4:0] sync_exc_code(input sync_flags_t f);
      logic [4:0] code;
      if (f.adel) begin
         code = EXC_ADEL;
      end else if (f.ades) begin
         code = EXC_ADES;
      end else if (f.ri) begin
         code = EXC_RI;
      end else if (f.sys) begin
         code = EXC_SYS;
      end else if (f.bp) begin
         code = EXC_BP;
      end else if (f.ov) begin
         code = EXC_OV;
      end else begin
         code = EXC_INT;
      end
      return code;
   endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One peripheral IRQ line: multi-flop synchroniser followed by either a
// sticky rising-edge latch (EDGE=1) or a registered copy of the level (EDGE=0).
module irq_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter bit EDGE        = 1'b1
) (
   input  logic clk,
   input  logic clr,
   input  logic irq,
   input  logic clr_pend,
   output logic pending
);

   logic [SYNC_STAGES-1:0] sync;
   logic                   prev;
   logic                   synced;

   assign synced = sync[SYNC_STAGES-1];

   // Synchroniser chain, edge history and pending latch; a new edge beats a clear.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync    <= '0;
         prev    <= 1'b0;
         pending <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], irq};
         prev <= synced;
         if (EDGE) begin
            if (synced && !prev) begin
               pending <= 1'b1;
            end else if (clr_pend) begin
               pending <= 1'b0;
            end else begin
               pending <= pending;
            end
         end else begin
            pending <= synced;
         end
      end
   end

endmodule

// File: rtl/exc_irq_controller.sv
// Source side of the COP0 exception interface: IRQ pending latches, exception
// prioritisation, the one-cycle exception strobe and handler/holdoff tracking.
module exc_irq_controller
   import exc_pkg::*;
#(
   parameter int         SYNC_STAGES  = 2,
   parameter logic [6:0] IRQ_EDGE     = 7'h7F,
   parameter int         ERET_HOLDOFF = 1
) (
   input  logic        iCLK,
   input  logic        iCLR,
   input  logic [6:0]  iIRQ,
   input  logic        iPendClrWe,
   input  logic [6:0]  iPendClrMask,
   output logic [7:0]  oPendingInterrupt,
   input  logic [7:0]  iInterruptMask,
   input  logic        iExcLevel,
   input  logic        iInstrValid,
   input  logic [31:0] iPC,
   input  logic        iInBranchDelay,
   input  logic        iAdEL,
   input  logic        iAdES,
   input  logic        iRI,
   input  logic        iSyscall,
   input  logic        iBreak,
   input  logic        iOverflow,
   input  logic        iEret,
   output logic        oExcOccurred,
   output logic [4:0]  oExcCode,
   output logic        oBranchDelay,
   output logic [31:0] oEPC,
   output logic        oInHandler
);

   localparam logic [3:0] HOLD_INIT = 4'(ERET_HOLDOFF);

   exc_state_e  state;
   logic [3:0]  holdoff_cnt;
   logic [6:0]  pending;
   sync_flags_t flags;
   logic        sync_req;
   logic        int_req;
   logic        take;
   logic [4:0]  take_code;
   logic [31:0] take_epc;

   for (genvar g = 0; g < NUM_IRQ; g++) begin : g_irq
      irq_sync_edge #(
         .SYNC_STAGES (SYNC_STAGES),
         .EDGE        (IRQ_EDGE[g])
      ) u_irq (
         .clk      (iCLK),
         .clr      (iCLR),
         .irq      (iIRQ[g]),
         .clr_pend (iPendClrWe & iPendClrMask[g]),
         .pending  (pending[g])
      );
   end

   // The pending latches are already flops, so they drive COP0 directly.
   assign oPendingInterrupt = {1'b0, pending};

   assign flags     = sync_flags_t'({iAdEL, iAdES, iRI, iSyscall, iBreak, iOverflow});
   assign sync_req  = iInstrValid & (flags != 6'b000000);
   assign int_req   = iInstrValid & (|iInterruptMask) & ~iExcLevel & (holdoff_cnt == 4'd0);
   assign take_code = sync_req ? sync_exc_code(flags) : EXC_INT;
   // An interrupted instruction has not executed, so the return lands on iPC.
   assign take_epc  = (iInBranchDelay || !sync_req) ? (iPC - 32'd4) : iPC;

   // Decide whether an exception is accepted in the current state; eret beats a sync exception.
   always_comb begin
      take = 1'b0;
      case (state)
         ST_IDLE:    take = sync_req | int_req;
         ST_HANDLER: take = sync_req & ~iEret;
         ST_HOLDOFF: take = sync_req;
         default:    take = 1'b0;
      endcase
   end

   // Exception FSM with registered strobe, cause, BD, EPC and handler flag.
   always_ff @(posedge iCLK) begin
      if (iCLR) begin
         state        <= ST_IDLE;
         holdoff_cnt  <= 4'd0;
         oExcOccurred <= 1'b0;
         oExcCode     <= 5'd0;
         oBranchDelay <= 1'b0;
         oEPC         <= 32'd0;
         oInHandler   <= 1'b0;
      end else begin
         oExcOccurred <= 1'b0;
         if (take) begin
            state        <= ST_TAKEN;
            holdoff_cnt  <= 4'd0;
            oExcOccurred <= 1'b1;
            oExcCode     <= take_code;
            oBranchDelay <= iInBranchDelay;
            oEPC         <= take_epc;
            oInHandler   <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state <= ST_IDLE;
               end
               ST_TAKEN: begin
                  state      <= ST_HANDLER;
                  oInHandler <= 1'b1;
               end
               ST_HANDLER: begin
                  if (iEret) begin
                     oInHandler <= 1'b0;
                     if (ERET_HOLDOFF == 0) begin
                        state <= ST_IDLE;
                     end else begin
                        state       <= ST_HOLDOFF;
                        holdoff_cnt <= HOLD_INIT;
                     end
                  end
               end
               ST_HOLDOFF: begin
                  if (holdoff_cnt <= 4'd1) begin
                     holdoff_cnt <= 4'd0;
                     state       <= ST_IDLE;
                  end else begin
                     holdoff_cnt <= holdoff_cnt - 4'd1;
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_exc_irq_controller.sv
// Bench for exc_irq_controller: directed vector table, hand-written corner
// sequences, then random stimulus checked against a cycle-level reference model.
module tb_exc_irq_controller;

   localparam int S  = 2;
   localparam int HO = 1;

   logic        iCLK = 1'b0;
   logic        iCLR;
   logic [6:0]  iIRQ;
   logic        iPendClrWe;
   logic [6:0]  iPendClrMask;
   logic [7:0]  oPendingInterrupt;
   logic [7:0]  iInterruptMask;
   logic        iExcLevel, iInstrValid, iInBranchDelay;
   logic [31:0] iPC;
   logic        iAdEL, iAdES, iRI, iSyscall, iBreak, iOverflow, iEret;
   logic        oExcOccurred, oBranchDelay, oInHandler;
   logic [4:0]  oExcCode;
   logic [31:0] oEPC;

   exc_irq_controller #(.SYNC_STAGES(S), .IRQ_EDGE(7'h7F), .ERET_HOLDOFF(HO)) dut (
      .iCLK(iCLK), .iCLR(iCLR), .iIRQ(iIRQ), .iPendClrWe(iPendClrWe),
      .iPendClrMask(iPendClrMask), .oPendingInterrupt(oPendingInterrupt),
      .iInterruptMask(iInterruptMask), .iExcLevel(iExcLevel), .iInstrValid(iInstrValid),
      .iPC(iPC), .iInBranchDelay(iInBranchDelay), .iAdEL(iAdEL), .iAdES(iAdES),
      .iRI(iRI), .iSyscall(iSyscall), .iBreak(iBreak), .iOverflow(iOverflow),
      .iEret(iEret), .oExcOccurred(oExcOccurred), .oExcCode(oExcCode),
      .oBranchDelay(oBranchDelay), .oEPC(oEPC), .oInHandler(oInHandler)
   );

   always #5 iCLK = ~iCLK;

   int checks = 0;
   int passes = 0;
   bit model_on = 1'b0;

   // reference model state
   logic [6:0]  hist [0:S+1];
   logic [6:0]  m_pend;
   logic        m_exc, m_inh, m_bd;
   int          m_hold;
   logic [4:0]  m_code;
   logic [31:0] m_epc;
   logic [4:0]  prio_codes [0:5];

   typedef struct {
      logic [5:0]  flags;      // {AdEL, AdES, RI, Sys, Bp, Ov}
      logic        bd;
      logic        valid;
      logic [7:0]  mask;
      logic        el;
      logic [31:0] pc;
      logic        exp_exc;
      logic [4:0]  exp_code;
      logic        exp_bd;
      logic [31:0] exp_epc;
   } vec_t;
   vec_t vecs [0:11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
      else passes++;
   endtask

   task automatic model_update();
      logic [5:0] f;
      logic any_sync, want_int, rise_bit;
      for (int j = S + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = iIRQ;
      if (iCLR) begin
         for (int j = 0; j <= S + 1; j++) hist[j] = 7'h00;
         m_pend = 7'h00; m_exc = 1'b0; m_inh = 1'b0; m_hold = 0;
         m_code = 5'd0; m_bd = 1'b0; m_epc = 32'd0;
      end else begin
         for (int i = 0; i < 7; i++) begin
            rise_bit = hist[S][i] & ~hist[S+1][i];
            if (rise_bit) m_pend[i] = 1'b1;
            else if (iPendClrWe && iPendClrMask[i]) m_pend[i] = 1'b0;
         end
         f = {iAdEL, iAdES, iRI, iSyscall, iBreak, iOverflow};
         any_sync = iInstrValid && (f != 6'd0);
         want_int = iInstrValid && (iInterruptMask != 8'd0) && !iExcLevel && !m_inh && (m_hold == 0);
         if (m_exc) begin
            m_exc = 1'b0; m_inh = 1'b1;
         end else if (m_inh && iEret) begin
            m_inh = 1'b0; m_hold = HO;
         end else if (any_sync || want_int) begin
            m_exc = 1'b1; m_inh = 1'b0; m_hold = 0; m_bd = iInBranchDelay;
            m_code = 5'd0;
            if (any_sync) begin
               for (int i = 0; i < 6; i++) begin
                  if (f[5-i]) begin m_code = prio_codes[i]; break; end
               end
            end
            m_epc = (iInBranchDelay || !any_sync) ? iPC - 32'd4 : iPC;
         end else if (m_hold > 0) begin
            m_hold--;
         end
      end
   endtask

   task automatic step();
      @(posedge iCLK);
      model_update();
      #1;
      if (model_on) begin
         chk("m_pend", {24'd0, oPendingInterrupt}, {25'd0, m_pend});
         chk("m_exc", {31'd0, oExcOccurred}, {31'd0, m_exc});
         chk("m_inh", {31'd0, oInHandler}, {31'd0, m_inh});
         if (m_exc) begin
            chk("m_code", {27'd0, oExcCode}, {27'd0, m_code});
            chk("m_bd", {31'd0, oBranchDelay}, {31'd0, m_bd});
            chk("m_epc", oEPC, m_epc);
         end
      end
   endtask

   task automatic zero_inputs();
      iIRQ = 7'h00; iPendClrWe = 1'b0; iPendClrMask = 7'h00; iInterruptMask = 8'h00;
      iExcLevel = 1'b0; iInstrValid = 1'b0; iPC = 32'd0; iInBranchDelay = 1'b0;
      iAdEL = 1'b0; iAdES = 1'b0; iRI = 1'b0; iSyscall = 1'b0; iBreak = 1'b0;
      iOverflow = 1'b0; iEret = 1'b0;
   endtask

   task automatic do_reset();
      iCLR = 1'b1; step(); iCLR = 1'b0;
   endtask

   task automatic chk_all_zero(input string name);
      chk({name, "_pend"}, {24'd0, oPendingInterrupt}, 32'd0);
      chk({name, "_exc"}, {31'd0, oExcOccurred}, 32'd0);
      chk({name, "_code"}, {27'd0, oExcCode}, 32'd0);
      chk({name, "_bd"}, {31'd0, oBranchDelay}, 32'd0);
      chk({name, "_epc"}, oEPC, 32'd0);
      chk({name, "_inh"}, {31'd0, oInHandler}, 32'd0);
   endtask

   initial begin
      prio_codes[0] = 5'd4; prio_codes[1] = 5'd5; prio_codes[2] = 5'd10;
      prio_codes[3] = 5'd8; prio_codes[4] = 5'd9; prio_codes[5] = 5'd12;
      for (int j = 0; j <= S + 1; j++) hist[j] = 7'h00;
      m_pend = 7'h00; m_exc = 1'b0; m_inh = 1'b0; m_hold = 0;
      m_code = 5'd0; m_bd = 1'b0; m_epc = 32'd0;

      vecs[0]  = '{6'b100001, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00400010, 1'b1, 5'd4,  1'b0, 32'h00400010};
      vecs[1]  = '{6'b000100, 1'b1, 1'b1, 8'h00, 1'b0, 32'h00400024, 1'b1, 5'd8,  1'b1, 32'h00400020};
      vecs[2]  = '{6'b001110, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00401000, 1'b1, 5'd10, 1'b0, 32'h00401000};
      vecs[3]  = '{6'b000010, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00402000, 1'b1, 5'd9,  1'b0, 32'h00402000};
      vecs[4]  = '{6'b000001, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00403000, 1'b1, 5'd12, 1'b0, 32'h00403000};
      vecs[5]  = '{6'b011000, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00404000, 1'b1, 5'd5,  1'b0, 32'h00404000};
      vecs[6]  = '{6'b000000, 1'b0, 1'b1, 8'h01, 1'b0, 32'h00000000, 1'b1, 5'd0,  1'b0, 32'hFFFFFFFC};
      vecs[7]  = '{6'b000000, 1'b0, 1'b1, 8'h01, 1'b1, 32'h00400000, 1'b0, 5'd0,  1'b0, 32'h00000000};
      vecs[8]  = '{6'b100000, 1'b0, 1'b0, 8'h01, 1'b0, 32'h00400000, 1'b0, 5'd0,  1'b0, 32'h00000000};
      vecs[9]  = '{6'b000000, 1'b0, 1'b1, 8'h00, 1'b0, 32'h00400000, 1'b0, 5'd0,  1'b0, 32'h00000000};
      vecs[10] = '{6'b000000, 1'b1, 1'b1, 8'h80, 1'b0, 32'h00000100, 1'b1, 5'd0,  1'b1, 32'h000000FC};
      vecs[11] = '{6'b000100, 1'b0, 1'b1, 8'hFF, 1'b1, 32'h00400030, 1'b1, 5'd8,  1'b0, 32'h00400030};

      zero_inputs();
      do_reset();
      chk_all_zero("reset");

      // IRQ latency and interrupt strobe
      iIRQ = 7'h01; step(); iIRQ = 7'h00;
      chk("lat1", {24'd0, oPendingInterrupt}, 32'h0);
      step(); chk("lat2", {24'd0, oPendingInterrupt}, 32'h0);
      step(); chk("lat3", {24'd0, oPendingInterrupt}, 32'h1);
      iInterruptMask = 8'h01; iInstrValid = 1'b1; iPC = 32'h00400100;
      step();
      chk("int_exc", {31'd0, oExcOccurred}, 32'd1);
      chk("int_code", {27'd0, oExcCode}, 32'd0);
      chk("int_epc", oEPC, 32'h004000FC);
      chk("int_bd", {31'd0, oBranchDelay}, 32'd0);

      // interrupt held off in handler, eret beats a same-cycle syscall, holdoff
      for (int i = 0; i < 4; i++) begin
         step();
         chk("hnd_noexc", {31'd0, oExcOccurred}, 32'd0);
         chk("hnd_inh", {31'd0, oInHandler}, 32'd1);
      end
      iEret = 1'b1; iSyscall = 1'b1; step(); iEret = 1'b0; iSyscall = 1'b0;
      chk("eret_noexc", {31'd0, oExcOccurred}, 32'd0);
      chk("eret_inh", {31'd0, oInHandler}, 32'd0);
      step(); chk("holdoff_noexc", {31'd0, oExcOccurred}, 32'd0);
      step(); chk("post_hold_exc", {31'd0, oExcOccurred}, 32'd1);
      iInterruptMask = 8'h00;
      step(); chk("no_double", {31'd0, oExcOccurred}, 32'd0);

      // sync exception inside the handler re-strobes and returns to the handler
      iOverflow = 1'b1; iPC = 32'h00400200; step(); iOverflow = 1'b0;
      chk("hov_exc", {31'd0, oExcOccurred}, 32'd1);
      chk("hov_code", {27'd0, oExcCode}, 32'd12);
      chk("hov_epc", oEPC, 32'h00400200);
      step();
      chk("hov_back", {31'd0, oInHandler}, 32'd1);
      chk("hov_once", {31'd0, oExcOccurred}, 32'd0);

      // a new edge beats a same-cycle clear; clear alone drops the bit
      iIRQ = 7'h01; step(); step();
      iPendClrWe = 1'b1; iPendClrMask = 7'h01; step();
      chk("set_wins", {31'd0, oPendingInterrupt[0]}, 32'd1);
      step();
      chk("clr_alone", {31'd0, oPendingInterrupt[0]}, 32'd0);
      iPendClrWe = 1'b0; iPendClrMask = 7'h00; iIRQ = 7'h00;

      // reset in the handler with pending 7'h05
      step(); step();
      iIRQ = 7'h05; step(); iIRQ = 7'h00; step(); step();
      chk("pend05", {24'd0, oPendingInterrupt}, 32'h05);
      chk("pend05_inh", {31'd0, oInHandler}, 32'd1);
      iCLR = 1'b1; step(); iCLR = 1'b0;
      chk_all_zero("midreset");
      step(); chk("midreset_noexc", {31'd0, oExcOccurred}, 32'd0);

      // single-instruction vectors from IDLE
      for (int v = 0; v < 12; v++) begin
         zero_inputs();
         do_reset();
         {iAdEL, iAdES, iRI, iSyscall, iBreak, iOverflow} = vecs[v].flags;
         iInBranchDelay = vecs[v].bd; iInstrValid = vecs[v].valid;
         iInterruptMask = vecs[v].mask; iExcLevel = vecs[v].el; iPC = vecs[v].pc;
         step();
         zero_inputs();
         chk($sformatf("vec%0d_exc", v), {31'd0, oExcOccurred}, {31'd0, vecs[v].exp_exc});
         if (vecs[v].exp_exc) begin
            chk($sformatf("vec%0d_code", v), {27'd0, oExcCode}, {27'd0, vecs[v].exp_code});
            chk($sformatf("vec%0d_bd", v), {31'd0, oBranchDelay}, {31'd0, vecs[v].exp_bd});
            chk($sformatf("vec%0d_epc", v), oEPC, vecs[v].exp_epc);
         end
      end

      // random stimulus against the reference model
      zero_inputs();
      do_reset();
      model_on = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         iCLR = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 3) == 0) iIRQ = 7'($urandom_range(0, 127));
         iPendClrWe = ($urandom_range(0, 7) == 0);
         iPendClrMask = 7'($urandom_range(0, 127));
         iInterruptMask = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
         iExcLevel = ($urandom_range(0, 3) == 0);
         iInstrValid = ($urandom_range(0, 3) != 0);
         iPC = $urandom;
         iInBranchDelay = ($urandom_range(0, 3) == 0);
         iAdEL = ($urandom_range(0, 39) == 0);
         iAdES = ($urandom_range(0, 39) == 0);
         iRI = ($urandom_range(0, 39) == 0);
         iSyscall = ($urandom_range(0, 39) == 0);
         iBreak = ($urandom_range(0, 39) == 0);
         iOverflow = ($urandom_range(0, 39) == 0);
         iEret = ($urandom_range(0, 5) == 0);
         step();
      end
      model_on = 1'b0;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
